load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage of the RV32I core. Sits directly downstream of the instruction decoder and ALU: it takes the decoded load/store strobes, the 3-bit access `Size` code and the ALU-computed address, and runs a request/acknowledge transaction on the data-memory bus. It stalls the core while the transaction is outstanding and returns the lane-selected, sign- or zero-extended load result to the register write-back mux.

## Interface

Parameters: none.

- `clk  in  1` — core clock; all state on rising edge.
- `rst  in  1` — asynchronous, active-high reset.
- `Load  in  1` — current instruction is a load (decoder `ResultSrc == 01`).
- `MemWrite  in  1` — current instruction is a store.
- `Size  in  3` — access size code: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 treated as word.
- `Addr  in  32` — byte address from ALU.
- `WriteData  in  32` — store data (rs2).
- `ReadData  out  32` — extended load result to write-back.
- `Stall  out  1` — hold PC/register-file write while high.
- `Misaligned  out  1` — misaligned-access flag (see Configuration).
- `bus_req  out  1` — memory request, registered.
- `bus_we  out  1` — 1 = write.
- `bus_addr  out  32` — word-aligned address, `{Addr[31:2],2'b00}` latched.
- `bus_be  out  4` — byte enables, little-endian.
- `bus_wdata  out  32` — lane-replicated store data.
- `bus_ack  in  1` — memory completion, one-cycle pulse.
- `bus_rdata  in  32` — read word, valid with `bus_ack`.

## Operation

- FSM states: IDLE, REQ, DONE.
- IDLE: if `(Load | MemWrite)` and access permitted → latch address, offset `Addr[1:0]`, size, `bus_we`, `bus_be`, `bus_wdata`; go to REQ. Else stay.
- `MemWrite` has priority when both strobes are high (treated as store).
- REQ: `bus_req = 1`, all bus outputs stable. On `bus_ack` → DONE; a load captures `bus_rdata`, extended, into `ReadData`. Without ack, stay (unbounded wait).
- DONE: one cycle, `Stall = 0`; core retires the instruction at this edge; → IDLE. No new access is launched from DONE (prevents re-issuing the same instruction).
- `Stall = (IDLE & (Load|MemWrite) & permitted) | REQ`. Combinational.
- Byte enables: word `1111`; half `0011 << {Addr[1],1'b0}`; byte `0001 << Addr[1:0]`.
- Store data: byte `{4{WriteData[7:0]}}`, half `{2{WriteData[15:0]}}`, word unchanged.
- Load extraction uses the latched offset: select byte/half lane, then sign-extend (011, 001) or zero-extend (100, 010); word passes through.
- `ReadData` changes only on load completion; stores leave it unchanged.
- `bus_ack` outside REQ is ignored.

## Timing

- Reset values: state IDLE, `ReadData = 0`, `bus_req = 0`, `bus_we = 0`, `bus_addr = 0`, `bus_be = 0`, `bus_wdata = 0`, `Misaligned = 0`; `Stall` follows from IDLE and the inputs.
- Zero-wait memory (ack in first REQ cycle): 3 cycles per memory instruction — IDLE (stall), REQ (stall), DONE (retire). Each wait state adds one REQ cycle.
- `ReadData` valid from the DONE cycle until the next load completes.
- Reset asserted in REQ: `bus_req` drops asynchronously; the pending access is abandoned and its ack is ignored.
- Back-to-back memory instructions: the second is detected in the IDLE cycle following DONE.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined: access is misaligned if word and `Addr[1:0] != 0`, or half and `Addr[0] == 1`. Misaligned access is not issued; `Misaligned` = 1 combinationally in that IDLE cycle, `Stall = 0`, no write, `ReadData` unchanged.
- Not defined: `Misaligned` tied 0; the offending low address bits are ignored (word uses `Addr[31:2]` only; half uses `Addr[1]` only) and the access proceeds normally.

## Test plan

- LB, `Size = 011`, `Addr = 0x103`, `bus_rdata = 0x80FF_1234`, zero-wait → `bus_be = 0001 << 3`, `ReadData = 0xFFFF_FF80` in DONE; `Stall` high exactly 2 cycles.
- SH, `Size = 001`, `Addr = 0x22`, `WriteData = 0x0000_BEEF` → `bus_we = 1`, `bus_addr = 0x20`, `bus_be = 1100`, `bus_wdata = 0xBEEF_BEEF`; `ReadData` unchanged.
- LW with ack after 3 wait states, `bus_rdata = 0xDEAD_BEEF` → `Stall` high 5 cycles, then `ReadData = 0xDEAD_BEEF`; bus outputs stable throughout REQ.
- LHU, `Size = 010`, `Addr = 0x2`, `bus_rdata = 0x9ABC_0000` → `ReadData = 0x0000_9ABC`. Then an immediate LB → second access starts in the cycle after DONE; exactly two requests seen.
- `rst` pulsed mid-REQ, ack arriving afterwards → `bus_req = 0` immediately, state IDLE, `ReadData = 0`, late ack ignored.
- With `LSU_MISALIGN_TRAP_EN`: LW at `0x101` → `Misaligned = 1`, `Stall = 0`, no `bus_req`. Without it: the same LW → request to `0x100` with `bus_be = 1111`.

Source files
------------

// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module      : load_store_unit_if
// Description : Data-memory request/acknowledge bus between the load/store
//               unit (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
    logic        bus_req;    // request, held high for the whole transaction
    logic        bus_we;     // 1 = write
    logic [31:0] bus_addr;   // word-aligned byte address
    logic [3:0]  bus_be;     // little-endian byte enables
    logic [31:0] bus_wdata;  // lane-replicated store data
    logic        bus_ack;    // one-cycle completion pulse
    logic [31:0] bus_rdata;  // read word, valid with bus_ack

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I data-memory access stage. Launches one bus transaction
//               per load/store, stalls the core while it is outstanding and
//               returns the lane-selected, sign/zero-extended load result.
//               Optional build macro LSU_MISALIGN_TRAP_EN: when defined,
//               misaligned word/half accesses are flagged and never issued;
//               when undefined the offending low address bits are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        Load,
    input  wire logic        MemWrite,
    input  wire logic [2:0]  Size,
    input  wire logic [31:0] Addr,
    input  wire logic [31:0] WriteData,
    output logic      [31:0] ReadData,
    output logic             Stall,
    output logic             Misaligned,
    load_store_unit_if.master bus
);

    // Access size codes; anything not listed behaves as a word access.
    localparam logic [2:0] c_SIZE_HALF_S = 3'b001;
    localparam logic [2:0] c_SIZE_HALF_U = 3'b010;
    localparam logic [2:0] c_SIZE_BYTE_S = 3'b011;
    localparam logic [2:0] c_SIZE_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched transaction
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_offset;
    logic [2:0]  r_size;
    logic [31:0] r_rdata;

    // Request decode
    logic        w_access;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_misalign;
    logic        w_launch;
    logic        w_complete;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Load extraction
    logic [31:0] w_rd_shift;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_rd_ext;

    assign w_access  = Load | MemWrite;
    assign w_is_half = (Size == c_SIZE_HALF_S) || (Size == c_SIZE_HALF_U);
    assign w_is_byte = (Size == c_SIZE_BYTE_S) || (Size == c_SIZE_BYTE_U);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_is_word;
    assign w_is_word  = !w_is_half && !w_is_byte;
    // A word must sit on a 4-byte boundary and a half on a 2-byte boundary.
    assign w_misalign = w_access &&
                        ((w_is_word && (Addr[1:0] != 2'b00)) ||
                         (w_is_half && Addr[0]));
`else
    // Without trapping, low address bits below the access size are ignored.
    assign w_misalign = 1'b0;
`endif

    // A new access may only start from IDLE; DONE never relaunches so the
    // retiring instruction is not issued twice.
    assign w_launch   = (r_state == ST_IDLE) && w_access && !w_misalign;
    assign w_complete = (r_state == ST_REQ) && bus.bus_ack;

    // Byte-enable generation from the incoming address and size.
    always_comb begin
        w_be = 4'b1111;
        if (w_is_byte) begin
            w_be = 4'b0001 << Addr[1:0];
        end else if (w_is_half) begin
            w_be = Addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Replicate store data into every lane so the enabled lane(s) carry it.
    always_comb begin
        w_wdata = WriteData;
        if (w_is_byte) begin
            w_wdata = {4{WriteData[7:0]}};
        end else if (w_is_half) begin
            w_wdata = {2{WriteData[15:0]}};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ack outside REQ has no effect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.bus_ack) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the transaction at launch and hold it stable for all of REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_offset <= 2'd0;
            r_size   <= 3'd0;
        end else if (w_launch) begin
            r_req    <= 1'b1;
            r_we     <= MemWrite;
            r_addr   <= {Addr[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_offset <= Addr[1:0];
            r_size   <= Size;
        end else if (w_complete) begin
            r_req    <= 1'b0;
        end
    end

    // Select the addressed lane of the returned word using the latched offset.
    assign w_rd_shift = bus.bus_rdata >> {r_offset, 3'b000};
    assign w_rd_byte  = w_rd_shift[7:0];
    assign w_rd_half  = r_offset[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

    // Sign- or zero-extend the selected lane according to the latched size.
    always_comb begin
        w_rd_ext = bus.bus_rdata;
        case (r_size)
            c_SIZE_HALF_S: w_rd_ext = {{16{w_rd_half[15]}}, w_rd_half};
            c_SIZE_HALF_U: w_rd_ext = {16'd0, w_rd_half};
            c_SIZE_BYTE_S: w_rd_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
            c_SIZE_BYTE_U: w_rd_ext = {24'd0, w_rd_byte};
            default:       w_rd_ext = bus.bus_rdata;
        endcase
    end

    // Load result register: only a completing load updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (w_complete && !r_we) begin
            r_rdata <= w_rd_ext;
        end
    end

    assign ReadData      = r_rdata;
    assign Stall         = w_launch || (r_state == ST_REQ);
    assign Misaligned    = !rst && (r_state == ST_IDLE) && w_misalign;

    assign bus.bus_req   = r_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Randomized scoreboard bench for load_store_unit with a
//               byte-addressed memory model and wait-state memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Load, MemWrite;
    logic [2:0]  Size;
    logic [31:0] Addr, WriteData;
    logic [31:0] ReadData;
    logic        Stall, Misaligned;

    load_store_unit_if bus_if ();

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Load       (Load),
        .MemWrite   (MemWrite),
        .Size       (Size),
        .Addr       (Addr),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .Misaligned (Misaligned),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_req    = 0;
    txn_t        exp_q[$];
    int          wait_q[$];
    logic [7:0]  memb [int unsigned];
    logic [31:0] last_load = 32'd0;
    bit          resp_en   = 1'b1;

    // monitor state
    txn_t        cur;
    bit          prev_req = 1'b0;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_byte(input int unsigned a);
        if (!memb.exists(a)) memb[a] = 8'($urandom);
        return memb[a];
    endfunction

    // access width in bytes for a size code
    function automatic int width_of(input logic [2:0] sz);
        if (sz == 3'd1 || sz == 3'd2) return 2;
        if (sz == 3'd3 || sz == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit trapped(input logic [2:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        int n;
        n = width_of(sz);
        return (n > 1) && ((a % n) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
        int n;
        int unsigned base;
        int v;
        n    = width_of(sz);
        base = a - (a % n);
        v    = 0;
        for (int i = 0; i < n; i++) v = v + (int'(get_byte(base + i)) << (8 * i));
        if (sz == 3'd1 && v >= 32768) v = v - 65536;
        if (sz == 3'd3 && v >= 128)   v = v - 256;
        return 32'(v);
    endfunction

    // Present one instruction (called just after a rising edge) and follow it
    // until it retires; leaves the bench just after the edge ending DONE.
    task automatic run_instr(input logic ld, input logic st, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd, input int waits);
        txn_t t;
        int n, stalls;
        int unsigned base;
        bit done;
        Load = ld; MemWrite = st; Size = sz; Addr = a; WriteData = wd;
        if (trapped(sz, a)) begin
            @(negedge clk);
            check("misaligned_flag", Misaligned, 1'b1);
            check("misaligned_stall", Stall, 1'b0);
            check("misaligned_noreq", bus_if.bus_req, 1'b0);
            @(posedge clk); #1;
            Load = 1'b0; MemWrite = 1'b0;
            @(negedge clk);
            check("misaligned_noreq_after", bus_if.bus_req, 1'b0);
            @(posedge clk); #1;
            return;
        end
        n       = width_of(sz);
        base    = a - (a % n);
        t.we    = st;
        t.addr  = a & 32'hFFFF_FFFC;
        t.be    = 4'(((1 << n) - 1) << (base % 4));
        for (int i = 0; i < 4; i++) t.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        if (st) begin
            t.rdata = last_load;
        end else begin
            t.rdata   = model_load(sz, a);
            last_load = t.rdata;
        end
        exp_q.push_back(t);
        wait_q.push_back(waits);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (c == 0) check("misaligned_low", Misaligned, 1'b0);
            if (Stall) stalls++;
            else done = 1'b1;
        end
        check("retire_in_time", done, 1'b1);
        check("stall_cycles", stalls, waits + 2);
        @(posedge clk); #1;
    endtask

    // Memory responder: acknowledges each request after its wait states and
    // applies byte-enabled writes to the shared byte memory.
    initial begin
        logic [31:0] word;
        int w;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (resp_en && bus_if.bus_req && !rst) begin
                w = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
                repeat (w) @(negedge clk);
                for (int i = 0; i < 4; i++) word[8*i +: 8] = get_byte(bus_if.bus_addr + i);
                if (bus_if.bus_we) begin
                    for (int i = 0; i < 4; i++)
                        if (bus_if.bus_be[i]) memb[bus_if.bus_addr + i] = bus_if.bus_wdata[8*i +: 8];
                    bus_if.bus_rdata = $urandom;
                end else begin
                    bus_if.bus_rdata = word;
                end
                bus_if.bus_ack = 1'b1;
                @(negedge clk);
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_rdata = $urandom;
            end
        end
    end

    // Monitor: pops the expected transaction when a request starts, checks
    // it stays stable through REQ, and checks ReadData in the DONE cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (prev_req && !bus_if.bus_req) begin
                    check("readdata_done", ReadData, cur.rdata);
                end
                if (bus_if.bus_req && !prev_req) begin
                    n_req++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_request: addr %h, none expected", bus_if.bus_addr);
                    end else begin
                        cur = exp_q.pop_front();
                        check("bus_we", bus_if.bus_we, cur.we);
                        check("bus_addr", bus_if.bus_addr, cur.addr);
                        check("bus_be", bus_if.bus_be, cur.be);
                        if (cur.we) check("bus_wdata", bus_if.bus_wdata, cur.wdata);
                    end
                    s_we = bus_if.bus_we; s_addr = bus_if.bus_addr;
                    s_be = bus_if.bus_be; s_wdata = bus_if.bus_wdata;
                end else if (bus_if.bus_req) begin
                    check("bus_stable", (s_we == bus_if.bus_we) && (s_addr == bus_if.bus_addr) &&
                          (s_be == bus_if.bus_be) && (s_wdata == bus_if.bus_wdata), 1'b1);
                end
                prev_req = bus_if.bus_req;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req0;
        rst = 1'b1; Load = 1'b0; MemWrite = 1'b0; Size = 3'd0; Addr = 32'd0; WriteData = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_req", bus_if.bus_req, 1'b0);
        check("rst_we", bus_if.bus_we, 1'b0);
        check("rst_addr", bus_if.bus_addr, 32'd0);
        check("rst_be", bus_if.bus_be, 4'd0);
        check("rst_wdata", bus_if.bus_wdata, 32'd0);
        check("rst_misaligned", Misaligned, 1'b0);
        check("rst_stall", Stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // LB from 0x103
        memb[32'h100] = 8'h34; memb[32'h101] = 8'h12; memb[32'h102] = 8'hFF; memb[32'h103] = 8'h80;
        run_instr(1'b1, 1'b0, 3'b011, 32'h103, 32'd0, 0);
        check("lb_result", ReadData, 32'hFFFF_FF80);
        Load = 1'b0;

        // SH to 0x22
        run_instr(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 0);
        check("sh_readdata_kept", ReadData, 32'hFFFF_FF80);
        check("sh_mem_lo", {memb[32'h23], memb[32'h22]}, 16'hBEEF);
        MemWrite = 1'b0;

        // LW with three wait states
        memb[32'h40] = 8'hEF; memb[32'h41] = 8'hBE; memb[32'h42] = 8'hAD; memb[32'h43] = 8'hDE;
        run_instr(1'b1, 1'b0, 3'b000, 32'h40, 32'd0, 3);
        check("lw_wait_result", ReadData, 32'hDEAD_BEEF);

        // LHU then back-to-back LB
        memb[32'h0] = 8'h00; memb[32'h1] = 8'h00; memb[32'h2] = 8'hBC; memb[32'h3] = 8'h9A;
        req0 = n_req;
        run_instr(1'b1, 1'b0, 3'b010, 32'h2, 32'd0, 0);
        check("lhu_result", ReadData, 32'h0000_9ABC);
        run_instr(1'b1, 1'b0, 3'b011, 32'h3, 32'd0, 0);
        check("lb_b2b_result", ReadData, 32'hFFFF_FF9A);
        Load = 1'b0;
        @(negedge clk);
        check("b2b_request_count", n_req - req0, 2);
        @(posedge clk); #1;

        // LW at misaligned 0x101
        run_instr(1'b1, 1'b0, 3'b000, 32'h101, 32'd0, 1);
        Load = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of REQ; the late ack must be ignored
        resp_en = 1'b0;
        begin
            txn_t t;
            t.we = 1'b0; t.addr = 32'h200; t.be = 4'hF; t.wdata = 32'd0; t.rdata = 32'd0;
            exp_q.push_back(t);
        end
        Load = 1'b1; MemWrite = 1'b0; Size = 3'd0; Addr = 32'h200;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_req_active", bus_if.bus_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_req_drop", bus_if.bus_req, 1'b0);
        check("rst_mid_readdata", ReadData, 32'd0);
        Load = 1'b0;
        #1;
        check("rst_mid_idle", Stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("late_ack_noreq", bus_if.bus_req, 1'b0);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        check("late_ack_readdata", ReadData, 32'd0);
        check("late_ack_stall", Stall, 1'b0);
        last_load = 32'd0;
        resp_en   = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic in a small window so loads see earlier stores
        for (int k = 0; k < 200; k++) begin
            logic ld, st;
            int sel;
            sel = $urandom_range(0, 9);
            ld  = (sel < 5) || (sel == 9);
            st  = !ld || (sel == 9);
            run_instr(ld, st, 3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 31),
                      $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                Load = 1'b0; MemWrite = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        Load = 1'b0; MemWrite = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
